// File: rtl/siphash_pkg.sv
// Shared definitions for the SipHash message sequencer: command opcodes,
// FSM state encoding and the command word width.
package siphash_pkg;

  localparam int CMD_W = 68;

  localparam logic [3:0] OPC_KEY0 = 4'b0000;
  localparam logic [3:0] OPC_KEY1 = 4'b0001;
  localparam logic [3:0] OPC_COMP = 4'b0010;
  localparam logic [3:0] OPC_FIN  = 4'b0011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LDK0,
    ST_LDK1,
    ST_ACCEPT,
    ST_COMP,
    ST_GUARD,
    ST_WAIT,
    ST_PAD,
    ST_FIN,
    ST_FGUARD,
    ST_FWAIT,
    ST_DONE
  } state_t;

  // Where the message stands once the core finishes the current compression.
  typedef enum logic [1:0] {
    PH_MORE,
    PH_PAD,
    PH_FIN
  } phase_t;

  function automatic logic [3:0] eff_bytes(input logic last, input logic [3:0] nb);
    if (!last || (nb > 4'd8)) return 4'd8;
    return nb;
  endfunction

endpackage

// File: rtl/siphash_last_block.sv
// Builds the SipHash final block: k tail bytes, zero fill, and the total
// length mod 256 in the top byte.
module siphash_last_block
  import siphash_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [3:0]  i_k,
  input  logic [7:0]  i_len,
  output logic [63:0] o_blk
);

  always_comb begin
    o_blk = '0;
    for (int i = 0; i < 7; i++) begin
      if (4'(i) < i_k) o_blk[8*i +: 8] = i_data[8*i +: 8];
    end
    o_blk[63:56] = i_len;
  end

endmodule

// File: rtl/siphash_msg_sequencer.sv
// Drives the SipHash core command port: key reload, one COMP per message
// word, final block/padding, FIN, and digest return over valid/ready.
module siphash_msg_sequencer
  import siphash_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [63:0]       msg_data,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [3:0]        msg_bytes,
  output logic              msg_ready,
  output logic              core_we,
  output logic [CMD_W-1:0]  core_cmd,
  input  logic              core_busy,
  input  logic [63:0]       core_result,
  output logic [63:0]       digest,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic              err
);

  localparam int CNT_W = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_t            r_state, w_state_nx;
  phase_t            r_phase, w_phase_nx;
  logic [7:0]        r_len, w_len_nx;
  logic [CNT_W-1:0]  r_wcnt, w_wcnt_nx;
  logic              r_key_loaded, w_key_acc;
  logic [127:0]      r_key;
  logic              r_key_ready;
  logic              r_core_we, w_we_nx;
  logic [CMD_W-1:0]  r_core_cmd, w_cmd_nx;
  logic [63:0]       r_digest;
  logic              r_digest_valid;
  logic              r_err, w_err_nx;

  logic [3:0]        w_nb;
  logic [63:0]       w_lb_data;
  logic [3:0]        w_lb_k;
  logic [7:0]        w_lb_len;
  logic [63:0]       w_lb;
  logic              w_accept;

  assign w_accept  = (r_state == ST_ACCEPT);
  assign w_nb      = eff_bytes(msg_last, msg_bytes);
  // In ACCEPT the block carries the tail beat; elsewhere it is the pure padding word.
  assign w_lb_data = w_accept ? msg_data : '0;
  assign w_lb_k    = w_accept ? w_nb : 4'd0;
  assign w_lb_len  = w_accept ? (r_len + {4'b0000, w_nb}) : r_len;

  siphash_last_block u_last_block (
    .i_data (w_lb_data),
    .i_k    (w_lb_k),
    .i_len  (w_lb_len),
    .o_blk  (w_lb)
  );

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_len_nx   = r_len;
    w_wcnt_nx  = r_wcnt;
    w_err_nx   = r_err;
    w_we_nx    = 1'b0;
    w_cmd_nx   = '0;
    w_key_acc  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (key_valid && r_key_ready) begin
          w_key_acc  = 1'b1;
          w_state_nx = ST_LDK0;
          w_we_nx    = 1'b1;
          w_cmd_nx   = {OPC_KEY0, key[63:0]};
        end else if (msg_valid && r_key_loaded) begin
          w_state_nx = ST_LDK0;
          w_we_nx    = 1'b1;
          w_cmd_nx   = {OPC_KEY0, r_key[63:0]};
        end
      end
      ST_LDK0: begin
        w_state_nx = ST_LDK1;
        w_we_nx    = 1'b1;
        w_cmd_nx   = {OPC_KEY1, r_key[127:64]};
      end
      ST_LDK1: begin
        w_state_nx = ST_ACCEPT;
        w_len_nx   = 8'd0;
        w_phase_nx = PH_MORE;
      end
      ST_ACCEPT: begin
        if (msg_valid) begin
          w_state_nx = ST_COMP;
          w_we_nx    = 1'b1;
          if (w_nb == 4'd8) begin
            w_len_nx   = r_len + 8'd8;
            w_cmd_nx   = {OPC_COMP, msg_data};
            w_phase_nx = msg_last ? PH_PAD : PH_MORE;
          end else begin
            w_len_nx   = w_lb_len;
            w_cmd_nx   = {OPC_COMP, w_lb};
            w_phase_nx = PH_FIN;
          end
        end
      end
      ST_COMP, ST_PAD: begin
        w_state_nx = ST_GUARD;
        w_wcnt_nx  = '0;
      end
      ST_GUARD:  w_state_nx = ST_WAIT;
      ST_WAIT: begin
        if (!core_busy) begin
          case (r_phase)
            PH_PAD: begin
              w_state_nx = ST_PAD;
              w_we_nx    = 1'b1;
              w_cmd_nx   = {OPC_COMP, w_lb};
              w_phase_nx = PH_FIN;
            end
            PH_FIN: begin
              w_state_nx = ST_FIN;
              w_we_nx    = 1'b1;
              w_cmd_nx   = {OPC_FIN, 64'd0};
            end
            default: w_state_nx = ST_ACCEPT;
          endcase
        end else if (r_wcnt == CNT_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
      end
      ST_FIN: begin
        w_state_nx = ST_FGUARD;
        w_wcnt_nx  = '0;
      end
      ST_FGUARD: w_state_nx = ST_FWAIT;
      ST_FWAIT: begin
        if (!core_busy) begin
          w_state_nx = ST_DONE;
        end else if (r_wcnt == CNT_LAST) begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (digest_ready) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so strobes coincide with their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_phase        <= PH_MORE;
      r_len          <= 8'd0;
      r_wcnt         <= '0;
      r_key_loaded   <= 1'b0;
      r_key_ready    <= 1'b0;
      r_core_we      <= 1'b0;
      r_core_cmd     <= '0;
      r_digest       <= 64'd0;
      r_digest_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_phase        <= w_phase_nx;
      r_len          <= w_len_nx;
      r_wcnt         <= w_wcnt_nx;
      r_key_loaded   <= r_key_loaded | w_key_acc;
      r_key_ready    <= (w_state_nx == ST_IDLE);
      r_core_we      <= w_we_nx;
      r_core_cmd     <= w_cmd_nx;
      r_digest_valid <= (w_state_nx == ST_DONE);
      r_err          <= w_err_nx;
      if ((r_state == ST_FWAIT) && !core_busy) r_digest <= core_result;
    end
  end

  always_ff @(posedge clk) begin
    if (w_key_acc) r_key <= key;
  end

  assign key_ready    = r_key_ready;
  assign msg_ready    = w_accept;
  assign core_we      = r_core_we;
  assign core_cmd     = r_core_cmd;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;
  assign err          = r_err;

endmodule

// File: doc/siphash_msg_sequencer.md
# siphash_msg_sequencer

Command sequencer that drives the `siphash` core's `we`/`cmd`/`busy` port from a key interface and a 64-bit message stream. For every message it:
- reloads the key;
- issues one compression command per 8-byte word;
- builds the SipHash final block (tail bytes plus length byte);
- issues finalize and returns the 64-bit digest on a valid/ready output.

It sits between the host-side stream logic and the core, and is the only block allowed to write core commands.

## Interface
- `BUSY_TIMEOUT`, default 255: maximum cycles to wait for core `busy` to drop before flagging `err`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `key` in 128: key; `key[63:0]` is k0, `key[127:64]` is k1.
- `key_valid` in 1: key offered.
- `key_ready` out 1: key accepted this cycle; high only in IDLE.
- `msg_data` in 64: message word, little-endian byte order.
- `msg_valid` in 1: word offered.
- `msg_last` in 1: final beat of the message.
- `msg_bytes` in 4: valid bytes on the last beat, 0..8; ignored (treated as 8) when `msg_last`=0.
- `msg_ready` out 1: word accepted when `msg_valid`&`msg_ready`.
- `core_we` out 1: one-cycle command strobe to the core.
- `core_cmd` out 68: `{opcode[3:0], data[63:0]}`.
- `core_busy` in 1: core busy.
- `core_result` in 64: core result.
- `digest` out 64: hash output, held while `digest_valid`.
- `digest_valid` out 1: digest available.
- `digest_ready` in 1: consumer accepts the digest.
- `err` out 1: sticky timeout flag; cleared only by `rst`.

## Operation
- Opcodes:
  - KEY0 = 4'b0000 (data k0)
  - KEY1 = 4'b0001 (data k1)
  - COMP = 4'b0010 (data message word)
  - FIN = 4'b0011 (data 0)
- States:
  - IDLE → LDK0 on `key_valid`; key latched internally.
  - A key stays latched until the next `key_valid` accepted in IDLE.
  - IDLE also → LDK0 when `msg_valid` and a key was previously latched.
  - LDK0 issues KEY0 → LDK1.
  - LDK1 issues KEY1 → ACCEPT; clears the 8-bit length counter.
  - ACCEPT: `msg_ready`=1.
    - Non-last beat: length += 8 (mod 256), then → COMP with the word.
    - Last beat with `msg_bytes`=8: length += 8, word → COMP, padding pending.
    - Last beat with `msg_bytes`<8: the word is merged into the final block → COMP.
  - COMP issues COMP → GUARD (1 cycle, `core_busy` ignored) → WAIT.
  - WAIT: when `core_busy`=0, the next state is:
    - ACCEPT if the message is not finished;
    - PAD if padding is pending;
    - FIN if the final block has been compressed.
  - PAD issues COMP with the final block → GUARD → WAIT.
  - FIN issues FIN → FGUARD → FWAIT.
  - FWAIT: when `core_busy`=0, capture `core_result` → DONE.
  - DONE: `digest_valid`=1; on `digest_ready` → IDLE.
- Final block:
  - bits [63:56] = total byte length mod 256;
  - bytes 0..k-1 = tail bytes; remaining bytes are zero;
  - k = `msg_bytes` (0..7), or 0 for the extra padding word.
  - Tail bytes beyond k in `msg_data` are masked to zero.
  - Length includes the tail bytes.
- An empty message is `msg_last`=1 with `msg_bytes`=0 on the first beat; its final block is 0x0000000000000000.
- `msg_bytes`>8 on a last beat is treated as 8.
- Timeout:
  - The wait counter runs in WAIT and FWAIT.
  - At `BUSY_TIMEOUT` cycles it sets `err`, discards the message and → IDLE; `digest_valid` is not asserted.
- `core_we` is only ever asserted when the last sampled `core_busy` was 0 and the state is not GUARD/FGUARD.

## Timing
- Reset values:
  - `key_ready`, `msg_ready`, `core_we`, `digest_valid`, `err` = 0;
  - `core_cmd`, `digest` = 0;
  - state = IDLE; no key latched.
- Every output is a register output; there are no combinational input→output paths.
  - Exception: `msg_ready`, which is decoded from state only.
- Key-to-first-ready latency:
  - key accept at cycle t;
  - KEY0 strobe at t+1;
  - KEY1 strobe at t+2;
  - `msg_ready` high at t+3.
- COMP strobe: the cycle after the beat is accepted.
- After a core `busy` fall, the next command or `msg_ready` follows 1 cycle later.
- `digest_valid` rises 1 cycle after `core_busy`=0 is seen in FWAIT.
- The digest is held stable until the handshake completes.
- A reset mid-message aborts immediately. The core must be reset alongside; the block does not drain the core.

## Structure
- Package `siphash_pkg` holds:
  - opcode constants `OPC_KEY0`, `OPC_KEY1`, `OPC_COMP`, `OPC_FIN`;
  - the state enum;
  - the `CMD_W`=68 width.
- Sub-module `siphash_last_block`: combinational, inputs (data, k, len) → 64-bit final block.
- The core itself is instantiated one level up, not inside this block.

## Test plan
- Key 0x0f0e…0100 (bytes 00..0f), empty message:
  - KEY0 data 0x0706050403020100, KEY1 data 0x0f0e0d0c0b0a0908;
  - one COMP with 0x0000000000000000, then FIN;
  - digest equals the software model (paper vector 0x726fdb47dd0e0e31).
- Same key, 15-byte message 00..0e:
  - COMP 0x0706050403020100;
  - COMP 0x0f0e0d0c0b0a0908 with byte 7 replaced by length 0x0f, i.e. 0x0f0e0d0c0b0a0908 with top byte 0x0f;
  - digest equals the model (0xa129ca6149be45e5).
- 8-byte message (`msg_bytes`=8): two COMPs, the second with data 0x0800000000000000.
- Core model holds `busy` high for 300 cycles:
  - `err`=1 after 255 waiting cycles;
  - FSM returns to IDLE; no `digest_valid`.
- Core `busy` stretched by random 0–20 cycles, and `digest_ready` held low for 10 cycles:
  - no `core_we` while busy;
  - digest stable until accepted.
- `rst` asserted mid-WAIT: all outputs return to reset values in the same cycle, and the next message reloads the key.
